// File: rtl/tdp_ram_ctrl_if.sv
// Request/response bundle between the two requesters and tdp_ram_ctrl.
// Port A and port B carry identical request and read-return signal sets.
interface tdp_ram_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 14
);
  localparam int NB = (DATA_WIDTH + 7) / 8;

  logic                  clear_req;
  logic                  busy;

  logic                  a_req;
  logic                  a_ready;
  logic [NB-1:0]         a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_ready;
  logic [NB-1:0]         b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  // Handshake: a request is taken on a rising edge where x_req & x_ready;
  // a stalled requester keeps x_req and its fields stable until taken.
  modport master (
    output clear_req,
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  busy,
    input  a_ready, a_rvalid, a_rdata,
    input  b_ready, b_rvalid, b_rdata
  );

  modport slave (
    input  clear_req,
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output busy,
    output a_ready, a_rvalid, a_rdata,
    output b_ready, b_rvalid, b_rdata
  );
endinterface

// File: rtl/tdp_ram_ctrl.sv
// True-dual-port RAM controller: per-port valid/ready, fixed read latency,
// A-wins same-address collision arbitration and a whole-array clear engine.
module tdp_ram_ctrl #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 14,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  tdp_ram_ctrl_if.slave       bus,
  output logic                dbg_clear_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int RL    = READ_LATENCY;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  collision;
  logic                  a_rd, a_wr, b_rd, b_wr;

  logic [RL-1:0]         a_vld_q, b_vld_q;
  logic [DATA_WIDTH-1:0] a_dat_q [RL];
  logic [DATA_WIDTH-1:0] b_dat_q [RL];

  // Only a write makes a same-address pair conflict; A always wins.
  assign collision = bus.a_req & bus.b_req & (bus.a_addr == bus.b_addr) &
                     ((|bus.a_we) | (|bus.b_we));

  assign bus.busy    = (state_q == CLEAR);
  assign dbg_clear_o = (state_q == CLEAR);
  assign bus.a_ready = (state_q == IDLE);
  assign bus.b_ready = (state_q == IDLE) & ~collision;

  assign a_rd = bus.a_req & bus.a_ready & ~(|bus.a_we);
  assign a_wr = bus.a_req & bus.a_ready &  (|bus.a_we);
  assign b_rd = bus.b_req & bus.b_ready & ~(|bus.b_we);
  assign b_wr = bus.b_req & bus.b_ready &  (|bus.b_we);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clear_req) state_q <= CLEAR;
        end
        CLEAR: begin
          if (cnt_q == '1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ports are stalled during a clear, and A/B never write the same word.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem_q[cnt_q] <= '0;
    if (a_wr) begin
      for (int j = 0; j < DATA_WIDTH; j++)
        if (bus.a_we[j/8]) mem_q[bus.a_addr][j] <= bus.a_wdata[j];
    end
    if (b_wr) begin
      for (int j = 0; j < DATA_WIDTH; j++)
        if (bus.b_we[j/8]) mem_q[bus.b_addr][j] <= bus.b_wdata[j];
    end
  end

  // Stage 0 samples the array before this edge's writes land; the last
  // stage is the output register and only moves when a read reaches it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_vld_q <= '0;
      b_vld_q <= '0;
      for (int k = 0; k < RL; k++) begin
        a_dat_q[k] <= '0;
        b_dat_q[k] <= '0;
      end
    end else begin
      a_vld_q[0] <= a_rd;
      b_vld_q[0] <= b_rd;
      if (a_rd) a_dat_q[0] <= mem_q[bus.a_addr];
      if (b_rd) b_dat_q[0] <= mem_q[bus.b_addr];
      for (int k = 1; k < RL; k++) begin
        a_vld_q[k] <= a_vld_q[k-1];
        b_vld_q[k] <= b_vld_q[k-1];
        if (a_vld_q[k-1]) a_dat_q[k] <= a_dat_q[k-1];
        if (b_vld_q[k-1]) b_dat_q[k] <= b_dat_q[k-1];
      end
    end
  end

  assign bus.a_rvalid = a_vld_q[RL-1];
  assign bus.a_rdata  = a_dat_q[RL-1];
  assign bus.b_rvalid = b_vld_q[RL-1];
  assign bus.b_rdata  = b_dat_q[RL-1];
endmodule
